// File: rtl/mf8x_pkg.sv
// Shared types and default widths for the mf8x load/store path.
package mf8x_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DISP_W   = 6;
    localparam int DEF_MAX_WAIT = 15;

    typedef enum logic [1:0] {
        PLAIN   = 2'b00,
        POSTINC = 2'b01,
        PREDEC  = 2'b10,
        DISP    = 2'b11
    } lsu_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/mf8x_ptr_agu.sv
// Combinational pointer address generator: effective address plus pointer write-back value.
module mf8x_ptr_agu
    import mf8x_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DISP_W = DEF_DISP_W
) (
    input  logic [ADDR_W-1:0] ptr_i,
    input  logic [DISP_W-1:0] disp_i,
    input  lsu_mode_t         mode_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] ptr_upd_o,
    output logic              ptr_wr_en_o
);

    // Arithmetic wraps modulo 2^ADDR_W; no carry or borrow is reported.
    always_comb begin
        addr_o      = ptr_i;
        ptr_upd_o   = ptr_i;
        ptr_wr_en_o = 1'b0;
        case (mode_i)
            POSTINC: begin
                ptr_upd_o   = ptr_i + ADDR_W'(1);
                ptr_wr_en_o = 1'b1;
            end
            PREDEC: begin
                addr_o      = ptr_i - ADDR_W'(1);
                ptr_upd_o   = ptr_i - ADDR_W'(1);
                ptr_wr_en_o = 1'b1;
            end
            DISP: begin
                addr_o = ptr_i + ADDR_W'(disp_i);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mf8x_lsu.sv
// Handshaken load/store unit: one RAM access per request, held until ram_ready or timeout.
module mf8x_lsu
    import mf8x_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DISP_W   = DEF_DISP_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Req_Wr,
    input  logic [1:0]        Req_Mode,
    input  logic [ADDR_W-1:0] Req_Ptr,
    input  logic [DISP_W-1:0] Req_Disp,
    input  logic [DATA_W-1:0] Req_WData,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] Rd_Data,
    output logic              Ptr_Wr,
    output logic [ADDR_W-1:0] Ptr_Upd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataout,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_datain,
    input  logic              ram_ready
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, upd_q, upd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              rd_q, rd_d, wr_q, wr_d, upd_en_q, upd_en_d;
    logic              done_q, done_d, err_q, err_d, ptr_wr_q, ptr_wr_d;

    logic [ADDR_W-1:0] agu_addr, agu_upd;
    logic              agu_en;

    mf8x_ptr_agu #(
        .ADDR_W (ADDR_W),
        .DISP_W (DISP_W)
    ) u_agu (
        .ptr_i       (Req_Ptr),
        .disp_i      (Req_Disp),
        .mode_i      (lsu_mode_t'(Req_Mode)),
        .addr_o      (agu_addr),
        .ptr_upd_o   (agu_upd),
        .ptr_wr_en_o (agu_en)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            upd_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            upd_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ptr_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            upd_q    <= upd_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            upd_en_q <= upd_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ptr_wr_q <= ptr_wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        upd_d    = upd_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        upd_en_d = upd_en_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ptr_wr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req) begin
                    state_d  = ACCESS;
                    cnt_d    = '0;
                    addr_d   = agu_addr;
                    upd_d    = agu_upd;
                    upd_en_d = agu_en;
                    wdata_d  = Req_WData;
                    rd_d     = ~Req_Wr;
                    wr_d     = Req_Wr;
                end
            end
            ACCESS: begin
                if (ram_ready) begin
                    if (rd_q) rdata_d = ram_datain;
                    done_d   = 1'b1;
                    ptr_wr_d = upd_en_q;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    state_d  = IDLE;
                end else if ((MAX_WAIT != 0) && (cnt_q == CNT_W'(MAX_WAIT))) begin
                    // Timeout: report the error but leave Rd_Data and the pointer untouched.
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy        = (state_q == ACCESS);
    assign Done        = done_q;
    assign Err         = err_q;
    assign Rd_Data     = rdata_q;
    assign Ptr_Wr      = ptr_wr_q;
    assign Ptr_Upd     = upd_q;
    assign ram_addr    = addr_q;
    assign ram_dataout = wdata_q;
    assign ram_read    = rd_q;
    assign ram_write   = wr_q;

endmodule

// File: tb/tb_mf8x_lsu.sv
// Directed bench for mf8x_lsu: each scenario task drives vectors and checks against hand-computed values.
module tb_mf8x_lsu;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic        Req_Wr = 1'b0;
    logic [1:0]  Req_Mode = 2'b00;
    logic [15:0] Req_Ptr = '0;
    logic [5:0]  Req_Disp = '0;
    logic [7:0]  Req_WData = '0;
    logic        Busy, Done, Err, Ptr_Wr, ram_read, ram_write;
    logic [7:0]  Rd_Data, ram_dataout;
    logic [15:0] Ptr_Upd, ram_addr;
    logic [7:0]  ram_datain = '0;
    logic        ram_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    mf8x_lsu dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req         (Req),
        .Req_Wr      (Req_Wr),
        .Req_Mode    (Req_Mode),
        .Req_Ptr     (Req_Ptr),
        .Req_Disp    (Req_Disp),
        .Req_WData   (Req_WData),
        .Busy        (Busy),
        .Done        (Done),
        .Err         (Err),
        .Rd_Data     (Rd_Data),
        .Ptr_Wr      (Ptr_Wr),
        .Ptr_Upd     (Ptr_Upd),
        .ram_addr    (ram_addr),
        .ram_dataout (ram_dataout),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_datain  (ram_datain),
        .ram_ready   (ram_ready)
    );

    always #5 Clk = ~Clk;

    // Called just after a negedge with the unit idle; returns at the negedge of cycle 1.
    task automatic issue(input logic wr, input logic [1:0] mode, input logic [15:0] ptr,
                         input logic [5:0] disp, input logic [7:0] wd);
        Req       = 1'b1;
        Req_Wr    = wr;
        Req_Mode  = mode;
        Req_Ptr   = ptr;
        Req_Disp  = disp;
        Req_WData = wd;
        @(negedge Clk);
        Req = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_cmp++; if ({Busy, Done, Err, Ptr_Wr} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {Busy, Done, Err, Ptr_Wr}); end
        n_cmp++; if ({ram_read, ram_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobes got %b want 00", {ram_read, ram_write}); end
        n_cmp++; if (ram_addr !== 16'h0000) begin n_err++; $display("FAIL reset_addr got %h want 0000", ram_addr); end
        n_cmp++; if (ram_dataout !== 8'h00) begin n_err++; $display("FAIL reset_dataout got %h want 00", ram_dataout); end
        n_cmp++; if (Rd_Data !== 8'h00) begin n_err++; $display("FAIL reset_rddata got %h want 00", Rd_Data); end
        n_cmp++; if (Ptr_Upd !== 16'h0000) begin n_err++; $display("FAIL reset_ptrupd got %h want 0000", Ptr_Upd); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_load_postinc();
        ram_ready  = 1'b1;
        ram_datain = 8'hA5;
        issue(1'b0, 2'b01, 16'h0100, 6'h00, 8'h00);
        n_cmp++; if ({Busy, ram_read, ram_write, Done} !== 4'b1100) begin n_err++; $display("FAIL ld01_c1_flags got %b want 1100", {Busy, ram_read, ram_write, Done}); end
        n_cmp++; if (ram_addr !== 16'h0100) begin n_err++; $display("FAIL ld01_addr got %h want 0100", ram_addr); end
        @(negedge Clk);
        n_cmp++; if ({Done, Err, Ptr_Wr, Busy, ram_read} !== 5'b10100) begin n_err++; $display("FAIL ld01_c2_flags got %b want 10100", {Done, Err, Ptr_Wr, Busy, ram_read}); end
        n_cmp++; if (Rd_Data !== 8'hA5) begin n_err++; $display("FAIL ld01_rddata got %h want a5", Rd_Data); end
        n_cmp++; if (Ptr_Upd !== 16'h0101) begin n_err++; $display("FAIL ld01_ptrupd got %h want 0101", Ptr_Upd); end
        @(negedge Clk);
        n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL ld01_done_pulse got %b want 0", Done); end
    endtask

    task automatic test_store_predec();
        ram_ready  = 1'b1;
        ram_datain = 8'h77;
        issue(1'b1, 2'b10, 16'h0000, 6'h00, 8'h3C);
        n_cmp++; if ({ram_write, ram_read} !== 2'b10) begin n_err++; $display("FAIL st10_strobes got %b want 10", {ram_write, ram_read}); end
        n_cmp++; if (ram_addr !== 16'hFFFF) begin n_err++; $display("FAIL st10_addr got %h want ffff", ram_addr); end
        n_cmp++; if (ram_dataout !== 8'h3C) begin n_err++; $display("FAIL st10_dataout got %h want 3c", ram_dataout); end
        @(negedge Clk);
        n_cmp++; if ({Done, Err, Ptr_Wr, ram_write} !== 4'b1010) begin n_err++; $display("FAIL st10_c2_flags got %b want 1010", {Done, Err, Ptr_Wr, ram_write}); end
        n_cmp++; if (Ptr_Upd !== 16'hFFFF) begin n_err++; $display("FAIL st10_ptrupd got %h want ffff", Ptr_Upd); end
        n_cmp++; if (Rd_Data !== 8'hA5) begin n_err++; $display("FAIL st10_rddata_hold got %h want a5", Rd_Data); end
        @(negedge Clk);
    endtask

    task automatic test_load_disp_wait();
        ram_ready  = 1'b0;
        ram_datain = 8'h5A;
        issue(1'b0, 2'b11, 16'h00F0, 6'h3F, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if ({ram_read, Done} !== 2'b10 || ram_addr !== 16'h012F) begin
                n_err++; $display("FAIL ld11_hold c%0d got rd/done %b addr %h want 10 012f", c, {ram_read, Done}, ram_addr);
            end
            if (c == 4) ram_ready = 1'b1;
            else @(negedge Clk);
        end
        @(negedge Clk);
        n_cmp++; if ({Done, Err, Ptr_Wr, Busy} !== 4'b1000) begin n_err++; $display("FAIL ld11_c5_flags got %b want 1000", {Done, Err, Ptr_Wr, Busy}); end
        n_cmp++; if (Rd_Data !== 8'h5A) begin n_err++; $display("FAIL ld11_rddata got %h want 5a", Rd_Data); end
        @(negedge Clk);
    endtask

    task automatic test_timeout();
        ram_ready  = 1'b0;
        ram_datain = 8'hEE;
        issue(1'b0, 2'b01, 16'h1234, 6'h00, 8'h00);
        for (int c = 1; c <= 16; c++) begin
            n_cmp++; if ({Busy, ram_read, Done} !== 3'b110) begin
                n_err++; $display("FAIL tmo_wait c%0d got %b want 110", c, {Busy, ram_read, Done});
            end
            @(negedge Clk);
        end
        n_cmp++; if ({Done, Err, ram_read, Ptr_Wr, Busy} !== 5'b11000) begin n_err++; $display("FAIL tmo_c17_flags got %b want 11000", {Done, Err, ram_read, Ptr_Wr, Busy}); end
        n_cmp++; if (Rd_Data !== 8'h5A) begin n_err++; $display("FAIL tmo_rddata_hold got %h want 5a", Rd_Data); end
        @(negedge Clk);
        n_cmp++; if ({Done, Err} !== 2'b00) begin n_err++; $display("FAIL tmo_pulse got %b want 00", {Done, Err}); end
    endtask

    task automatic test_back_to_back();
        int dones;
        ram_ready  = 1'b1;
        ram_datain = 8'h11;
        exp_q.push_back(8'h11);
        issue(1'b0, 2'b00, 16'h0200, 6'h00, 8'h00);
        exp_q.push_back(8'h22);
        issue(1'b0, 2'b01, 16'h0300, 6'h00, 8'h00);
        // cycle 2 of A is sampled at the same negedge where B was just launched
        n_cmp++; if (Done !== 1'b1 || Rd_Data !== exp_q[0]) begin n_err++; $display("FAIL b2b_a_done got %b/%h want 1/%h", Done, Rd_Data, exp_q[0]); end
        void'(exp_q.pop_front());
        Req = 1'b1; Req_Ptr = 16'h0300; Req_Mode = 2'b01;
        // previous issue() already dropped Req after edge; reissue B explicitly in the Done cycle
        @(negedge Clk);
        Req = 1'b0;
        ram_datain = 8'h22;
        n_cmp++; if ({Busy, ram_read} !== 2'b11 || ram_addr !== 16'h0300) begin n_err++; $display("FAIL b2b_b_strobe got %b addr %h want 11 0300", {Busy, ram_read}, ram_addr); end
        @(negedge Clk);
        n_cmp++; if (Done !== 1'b1 || Rd_Data !== exp_q[0] || Ptr_Upd !== 16'h0301) begin n_err++; $display("FAIL b2b_b_done got %b/%h/%h want 1/%h/0301", Done, Rd_Data, Ptr_Upd, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge Clk);
        // extra Req pulses during ACCESS must be ignored
        ram_ready  = 1'b0;
        ram_datain = 8'h33;
        exp_q.push_back(8'h33);
        issue(1'b0, 2'b00, 16'h0400, 6'h00, 8'h00);
        Req = 1'b1; Req_Ptr = 16'h0500;
        for (int c = 1; c <= 3; c++) begin
            n_cmp++; if (ram_addr !== 16'h0400) begin n_err++; $display("FAIL b2b_ignore c%0d addr %h want 0400", c, ram_addr); end
            if (c < 3) @(negedge Clk);
        end
        Req = 1'b0;
        ram_ready = 1'b1;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (Done) begin
                dones++;
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra_done rd %h want none", Rd_Data); end
                else if (Rd_Data !== exp_q.pop_front()) begin n_err++; $display("FAIL b2b_ign_rddata got %h want 33", Rd_Data); end
            end
        end
        n_cmp++; if (dones != 1 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_done_count got %0d left %0d want 1 0", dones, exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        ram_ready = 1'b0;
        issue(1'b0, 2'b01, 16'h0600, 6'h00, 8'h00);
        n_cmp++; if ({Busy, ram_read} !== 2'b11) begin n_err++; $display("FAIL rst_mid_pre got %b want 11", {Busy, ram_read}); end
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if ({Busy, ram_read, ram_write, Done} !== 4'b0000) begin n_err++; $display("FAIL rst_mid_async got %b want 0000", {Busy, ram_read, ram_write, Done}); end
        @(negedge Clk);
        Reset = 1'b0;
        ram_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            n_cmp++; if ({Done, Busy} !== 2'b00) begin n_err++; $display("FAIL rst_mid_nodone got %b want 00", {Done, Busy}); end
        end
        ram_datain = 8'h44;
        issue(1'b0, 2'b00, 16'h0700, 6'h00, 8'h00);
        n_cmp++; if (ram_addr !== 16'h0700 || ram_read !== 1'b1) begin n_err++; $display("FAIL rst_mid_req addr %h rd %b want 0700 1", ram_addr, ram_read); end
        @(negedge Clk);
        n_cmp++; if (Done !== 1'b1 || Rd_Data !== 8'h44) begin n_err++; $display("FAIL rst_mid_done got %b/%h want 1/44", Done, Rd_Data); end
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_load_postinc();
        test_store_predec();
        test_load_disp_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
